// File: rtl/an_sec_decode_ctrl.sv
// Sequential single-error-correcting AN-code decoder sharing one restoring divider over residue, syndrome search and corrected-quotient phases.
// Latency: out_valid rises 3*W_WIDTH+2 edges after the accepting edge.
// Backpressure: result is held in DONE until out_ready, and no new word is accepted until the state returns to IDLE.
module an_sec_decode_ctrl #(
    parameter int A       = 665,
    parameter int W_WIDTH = 14,
    parameter int N_WIDTH = 4,
    parameter int R_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_WIDTH-1:0] in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] out_data,
    output logic [R_WIDTH-1:0] out_syndrome,
    output logic               out_corrected,
    output logic               out_uncorrectable,
    output logic               out_overflow,
    output logic               busy
);

    localparam int CW = $clog2(W_WIDTH);
    localparam int WC = W_WIDTH + 2;
    localparam logic [CW-1:0]    CNT_LAST = CW'(W_WIDTH - 1);
    localparam logic [R_WIDTH:0] A_EXT    = (R_WIDTH + 1)'(A);

    typedef enum logic [2:0] {IDLE, DIV1, SEARCH, CORR, DIV2, DONE} state_t;

    state_t state, state_nxt;

    logic [W_WIDTH-1:0] wreg;      // captured codeword
    logic [W_WIDTH-1:0] dvd;       // dividend shift register, MSB consumed first
    logic [R_WIDTH-1:0] rem;       // running remainder (always < A)
    logic [W_WIDTH-1:0] quo;       // quotient shift register
    logic [CW-1:0]      cnt;       // bit / search index
    logic [R_WIDTH-1:0] p;         // 2^i mod A
    logic               match;
    logic               neg;       // matched syndrome was A - 2^i
    logic [CW-1:0]      idx;
    logic               fix_corr;
    logic               fix_unc;

    // One restoring-division step: shift in next dividend bit, subtract A if it fits.
    logic [R_WIDTH:0]   div_trial;
    logic               div_ge;
    logic [R_WIDTH-1:0] div_rem_nxt;
    assign div_trial   = {rem, dvd[W_WIDTH-1]};
    assign div_ge      = (div_trial >= A_EXT);
    assign div_rem_nxt = div_ge ? R_WIDTH'(div_trial - A_EXT) : div_trial[R_WIDTH-1:0];

    // Power-of-two residue walk and syndrome comparison.
    logic [R_WIDTH:0]   p2;
    logic [R_WIDTH-1:0] p_nxt;
    logic               hit_pos;
    logic               hit_neg;
    logic               syn_nz;
    assign p2      = {p, 1'b0};
    assign p_nxt   = (p2 >= A_EXT) ? R_WIDTH'(p2 - A_EXT) : p2[R_WIDTH-1:0];
    assign syn_nz  = (out_syndrome != '0);
    assign hit_pos = (out_syndrome == p);
    assign hit_neg = ({1'b0, out_syndrome} == (A_EXT - {1'b0, p}));

    // Corrected word: W - Delta, with two guard bits so underflow and overflow both show in the top bits.
    logic [WC-1:0] pow;
    logic [WC-1:0] wc_calc;
    logic          wc_ok;
    assign pow     = WC'(1) << idx;
    assign wc_calc = neg ? ({2'b00, wreg} + pow) : ({2'b00, wreg} - pow);
    assign wc_ok   = (wc_calc[WC-1:WC-2] == 2'b00);

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Phase sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)                state_nxt = DIV1;
            DIV1:    if (cnt == CNT_LAST)         state_nxt = SEARCH;
            SEARCH:  if (cnt == CNT_LAST)         state_nxt = CORR;
            CORR:                                 state_nxt = DIV2;
            DIV2:    if (cnt == CNT_LAST)         state_nxt = DONE;
            DONE:    if (out_valid && out_ready)  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers for each phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg              <= '0;
            dvd               <= '0;
            rem               <= '0;
            quo               <= '0;
            cnt               <= '0;
            p                 <= '0;
            match             <= 1'b0;
            neg               <= 1'b0;
            idx               <= '0;
            fix_corr          <= 1'b0;
            fix_unc           <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            out_overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wreg <= in_word;
                        dvd  <= in_word;
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                DIV1: begin
                    rem <= div_rem_nxt;
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        out_syndrome <= div_rem_nxt;
                        cnt          <= '0;
                        p            <= R_WIDTH'(1);
                        match        <= 1'b0;
                        neg          <= 1'b0;
                        idx          <= '0;
                    end
                end
                SEARCH: begin
                    // First hit wins: lowest index, positive before negative.
                    if (syn_nz && !match) begin
                        if (hit_pos) begin
                            match <= 1'b1;
                            neg   <= 1'b0;
                            idx   <= cnt;
                        end else if (hit_neg) begin
                            match <= 1'b1;
                            neg   <= 1'b1;
                            idx   <= cnt;
                        end
                    end
                    p   <= p_nxt;
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                CORR: begin
                    if (syn_nz && match && wc_ok) begin
                        dvd      <= wc_calc[W_WIDTH-1:0];
                        fix_corr <= 1'b1;
                        fix_unc  <= 1'b0;
                    end else begin
                        dvd      <= wreg;
                        fix_corr <= 1'b0;
                        fix_unc  <= syn_nz;
                    end
                    rem <= '0;
                    quo <= '0;
                    cnt <= '0;
                end
                DIV2: begin
                    rem <= div_rem_nxt;
                    dvd <= dvd << 1;
                    quo <= {quo[W_WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    // Publish once on entry, then hold until the consumer takes it.
                    if (!out_valid) begin
                        out_valid         <= 1'b1;
                        out_data          <= quo[N_WIDTH-1:0];
                        out_overflow      <= |quo[W_WIDTH-1:N_WIDTH];
                        out_corrected     <= fix_corr;
                        out_uncorrectable <= fix_unc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
module tb_an_sec_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_data;
    logic [9:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic        out_overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    an_sec_decode_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .out_overflow      (out_overflow),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Present a word, accept it, wait for the result and check latency and all fields, then hand it off.
    task automatic run_word(input string name, input logic [13:0] w, input logic [3:0] e_data,
                            input logic [9:0] e_syn, input logic e_corr, input logic e_unc,
                            input logic e_ovf);
        int n;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before_accept: got %b expected 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 44) begin
            errors++; $display("FAIL %s latency: got %0d expected 44", name, n);
        end
        checks++;
        if (out_data !== e_data) begin
            errors++; $display("FAIL %s data: got %0d expected %0d", name, out_data, e_data);
        end
        checks++;
        if (out_syndrome !== e_syn) begin
            errors++; $display("FAIL %s syndrome: got %0d expected %0d", name, out_syndrome, e_syn);
        end
        checks++;
        if ({out_corrected, out_uncorrectable, out_overflow} !== {e_corr, e_unc, e_ovf}) begin
            errors++; $display("FAIL %s flags(corr,unc,ovf): got %b%b%b expected %b%b%b", name,
                               out_corrected, out_uncorrectable, out_overflow, e_corr, e_unc, e_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s handoff(valid,ready): got %b%b expected 01", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy, out_data, out_syndrome, out_corrected, out_uncorrectable, out_overflow}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_state: got ready=%b valid=%b busy=%b data=%0d syn=%0d expected ready=1 others 0",
                               in_ready, out_valid, busy, out_data, out_syndrome);
        end
    endtask

    task automatic test_clean();
        run_word("clean_3325", 14'd3325, 4'd5, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pos_error();
        run_word("pos_3389", 14'd3389, 4'd5, 10'd64, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_neg_error();
        run_word("neg_2301", 14'd2301, 4'd5, 10'd306, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_top_bit_error();
        run_word("top_11517", 14'd11517, 4'd5, 10'd212, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_uncorrectable();
        run_word("nomatch_3328", 14'd3328, 4'd5, 10'd3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        run_word("ovf_13300", 14'd13300, 4'd4, 10'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Syndrome 53 matches +2^11, but 53-2048 is negative, so the correction is refused.
    task automatic test_out_of_range();
        run_word("range_53", 14'd53, 4'd0, 10'd53, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        int bad_stable;
        int bad_ready;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_word  = 14'd3325;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid_timeout: got %b expected 1", out_valid);
        end
        in_valid   = 1'b1;
        in_word    = 14'd3389;
        bad_stable = 0;
        bad_ready  = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 4'd5 || out_syndrome !== 10'd0 ||
                out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) bad_stable++;
            if (in_ready !== 1'b0) bad_ready++;
        end
        checks++;
        if (bad_stable !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad_stable);
        end
        checks++;
        if (bad_ready !== 0) begin
            errors++; $display("FAIL bp_in_ready: got %0d cycles with in_ready expected 0", bad_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_transfer(valid,ready): got %b%b expected 01", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_ignored_word busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_search();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_word  = 14'd3389;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || out_syndrome !== 10'd64) begin
            errors++; $display("FAIL mid_search(busy,syn): got %b,%0d expected 1,64", busy, out_syndrome);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_data, out_syndrome, out_corrected, out_uncorrectable, out_overflow}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset: got ready=%b valid=%b busy=%b syn=%0d expected ready=1 others 0",
                               in_ready, out_valid, busy, out_syndrome);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_word("after_reset_3325", 14'd3325, 4'd5, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word("b2b_a_3389", 14'd3389, 4'd5, 10'd64, 1'b1, 1'b0, 1'b0);
        run_word("b2b_b_13300", 14'd13300, 4'd4, 10'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_clean();
        test_pos_error();
        test_neg_error();
        test_top_bit_error();
        test_uncorrectable();
        test_overflow();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_search();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
